// File: rtl/vpu_fp_pkg.sv
// Shared FP32 field layout and reduction-sequencer state encoding
// for the vector FP unit.
package vpu_fp_pkg;

  localparam int SIGN_BIT = 31;
  localparam int EXP_W    = 8;
  localparam int MANT_W   = 23;
  localparam int EXP_LSB  = MANT_W;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    RS_IDLE,
    RS_RUN,
    RS_DONE
  } redsum_state_t;

endpackage

// File: rtl/fp_vredsum_seq.sv
// Unordered FP sum-reduction sequencer: streams vs2 elements into
// an external adder and accumulates onto vs1[0].
module fp_vredsum_seq
  import vpu_fp_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int VLEN_MAX = 32,
  parameter int AW       = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [AW:0]      vl,
  input  logic [WIDTH-1:0] scalar_init,
  input  logic             flush,
  output logic             rd_en,
  output logic [AW-1:0]    rd_addr,
  input  logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_sub,
  input  logic [WIDTH-1:0] add_y,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  input  logic             result_ready
);

  localparam logic [AW:0] VMAX = (AW+1)'(VLEN_MAX);

  redsum_state_t state, state_n;

  logic [WIDTH-1:0] acc, acc_n;
  logic [AW:0]      idx, idx_n;
  logic [AW:0]      vl_q, vl_n;
  logic             pend, pend_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RS_IDLE;
      acc   <= '0;
      idx   <= '0;
      vl_q  <= '0;
      pend  <= 1'b0;
    end else begin
      state <= state_n;
      acc   <= acc_n;
      idx   <= idx_n;
      vl_q  <= vl_n;
      pend  <= pend_n;
    end
  end

  always_comb begin
    state_n = state;
    acc_n   = acc;
    idx_n   = idx;
    vl_n    = vl_q;
    rd_en   = 1'b0;

    // Data for the read issued last cycle is on rd_data now.
    if (pend) acc_n = add_y;

    unique case (state)
      RS_IDLE: begin
        if (start) begin
          acc_n   = scalar_init;
          vl_n    = (vl > VMAX) ? VMAX : vl;
          idx_n   = '0;
          state_n = RS_RUN;
        end
      end
      RS_RUN: begin
        if (idx < vl_q) begin
          rd_en = 1'b1;
          idx_n = idx + 1'b1;
        end else begin
          state_n = RS_DONE;
        end
      end
      RS_DONE: begin
        if (result_ready) state_n = RS_IDLE;
      end
      default: state_n = RS_IDLE;
    endcase

    if (flush) begin
      state_n = RS_IDLE;
      rd_en   = 1'b0;
      acc_n   = acc;
    end

    pend_n = rd_en;
  end

  assign rd_addr      = idx[AW-1:0];
  assign add_a        = acc;
  assign add_b        = rd_data;
  assign add_sub      = 1'b0;
  assign busy         = (state != RS_IDLE);
  assign result       = acc;
  assign result_valid = (state == RS_DONE) && !flush;

endmodule
